swap_endian_stream: RTL

Registered, mode-configurable byte-order converter for Versat datapaths; successor to the single-mode 32-bit combinational swapper.
- Reverses bytes within 16-bit lanes, 32-bit lanes, or the full DATA_W word, or passes data through.
- Configuration is latched on `run`.
- Output is gated by a programmable start delay, so the unit aligns with upstream memory/stream units in the accelerator graph.
- Output is registered, latency 1.

---
 rtl/swap_endian_stream.sv | 133 +++++++++++++
 1 files changed

// File: rtl/swap_endian_stream.sv
// Registered byte-order converter: swaps bytes within 16-bit lanes, 32-bit lanes,
// or the whole word, with a programmable start delay after each run pulse.
module swap_endian_stream #(
    parameter int DATA_W  = 32,
    parameter int DELAY_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              running,
    input  logic              run,
    output logic              done,
    input  logic [DATA_W-1:0] in0,
    output logic [DATA_W-1:0] out0,
    input  logic              enabled,
    input  logic [1:0]        mode,
    input  logic [DELAY_W-1:0] delay0
);

    localparam int B = DATA_W / 8;
    localparam logic [DELAY_W-1:0] CNT_ONE  = DELAY_W'(1);
    localparam logic [DELAY_W-1:0] CNT_ZERO = DELAY_W'(0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t             state_r;
    logic               enabled_r;
    logic [1:0]         mode_r;
    logic [DELAY_W-1:0] count_r;
    logic [DATA_W-1:0]  out0_r;
    logic               done_r;

    // Trailing bytes that do not fill a whole lane are left where they are.
    function automatic logic [DATA_W-1:0] swap_bytes(
        input logic [DATA_W-1:0] d,
        input logic              en,
        input logic [1:0]        m
    );
        logic [DATA_W-1:0] r;
        r = d;
        if (en) begin
            case (m)
                2'd1: begin
                    for (int k = 0; k < B / 2; k++) begin
                        r[16*k +: 8]   = d[16*k+8 +: 8];
                        r[16*k+8 +: 8] = d[16*k +: 8];
                    end
                end
                2'd2: begin
                    for (int k = 0; k < B / 4; k++) begin
                        for (int j = 0; j < 4; j++) begin
                            r[32*k+8*j +: 8] = d[32*k+8*(3-j) +: 8];
                        end
                    end
                end
                2'd3: begin
                    for (int i = 0; i < B; i++) begin
                        r[8*i +: 8] = d[8*(B-1-i) +: 8];
                    end
                end
                default: r = d;
            endcase
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Control FSM, delay counter, config shadow and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            out0_r    <= '0;
            done_r    <= 1'b1;
            enabled_r <= 1'b0;
            mode_r    <= 2'd0;
            count_r   <= CNT_ZERO;
        end else if (!running) begin
            state_r <= IDLE;
            out0_r  <= '0;
            done_r  <= 1'b1;
            count_r <= CNT_ZERO;
        end else if (run) begin
            // A new run discards the old config; with zero delay the new config applies this edge.
            enabled_r <= enabled;
            mode_r    <= mode;
            count_r   <= delay0;
            if (delay0 == CNT_ZERO) begin
                state_r <= ACTIVE;
                done_r  <= 1'b1;
                out0_r  <= swap_bytes(in0, enabled, mode);
            end else begin
                state_r <= WAIT;
                done_r  <= 1'b0;
                out0_r  <= '0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    out0_r <= '0;
                    done_r <= 1'b1;
                end
                WAIT: begin
                    out0_r  <= '0;
                    count_r <= count_r - CNT_ONE;
                    if (count_r == CNT_ONE) begin
                        state_r <= ACTIVE;
                        done_r  <= 1'b1;
                    end else begin
                        done_r  <= 1'b0;
                    end
                end
                ACTIVE: begin
                    out0_r <= swap_bytes(in0, enabled_r, mode_r);
                    done_r <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    out0_r  <= '0;
                    done_r  <= 1'b1;
                    count_r <= CNT_ZERO;
                end
            endcase
        end
    end

    assign out0 = out0_r;
    assign done = done_r;

endmodule
